ex_muldiv_sequencer: RTL
========================

EX_MULDIV_SEQUENCER -- requirements
Module: ex_muldiv_sequencer

Interface
REQ-001 The block SHALL have no parameters; the operand width is fixed at 32 bits.
REQ-002 CLK  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 RESET  input  1  asynchronous, active-low reset.
REQ-004 I_MD_Start  input  1  request to start an operation this cycle.
REQ-005 I_MD_Op  input  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 I_MD_A  input  32  operand A (rs); the dividend for divides.
REQ-007 I_MD_B  input  32  operand B (rt); the divisor for divides.
REQ-008 I_MD_MfReq  input  1  an MFHI/MFLO is in EX this cycle.
REQ-009 I_MD_Flush  input  1  synchronous abort of the current operation.
REQ-010 HI_out  output  32  architectural HI register.
REQ-011 LO_out  output  32  architectural LO register.
REQ-012 busy_out  output  1  high while the state is CALC or FIX.
REQ-013 done_out  output  1  one-cycle pulse, high while the state is DONE.
REQ-014 stall_out  output  1  pipeline hold request; this output is combinational.
REQ-015 divZero_out  output  1  sticky flag for the last accepted divide with B==0.

Function
REQ-016 The block SHALL implement four states: IDLE, CALC, FIX and DONE.
REQ-017 A start is accepted when I_MD_Start=1, I_MD_Flush=0 and the state is IDLE or DONE.
  - Any start in CALC or FIX SHALL be ignored.
REQ-018 On an accepted start the block SHALL:
  - latch Op and the sign bits of A and B;
  - latch |A| and |B| for signed ops, and raw A and B for unsigned ops;
  - clear the 5-bit iteration counter and clear divZero_out;
  - go to CALC.
REQ-019 Exception: an accepted DIV or DIVU with B==0 SHALL:
  - go directly to DONE;
  - set divZero_out=1;
  - leave HI_out and LO_out unchanged.
REQ-020 CALC SHALL perform one iteration per cycle and increment the counter.
  - Multiply: shift-add, one multiplier bit per cycle, into a 64-bit product.
  - Divide: restoring division, one quotient bit per cycle.
REQ-021 After the 32nd iteration (counter==31 at the edge) the state SHALL go to FIX; the counter SHALL NOT wrap back into CALC.
REQ-022 On the FIX edge the block SHALL apply sign correction and write HI_out/LO_out, then go to DONE.
  - Multiply: {HI,LO} = A*B as a 64-bit result; signed ops negate it if signA^signB.
  - Divide: LO = quotient, negated if signA^signB; HI = remainder, negated if signA.
REQ-023 Signed DIV of 0x80000000 by 0xFFFFFFFF SHALL give LO=0x80000000 and HI=0x00000000.
REQ-024 Latency: done_out SHALL go high exactly 34 cycles after the accepting edge (32 CALC + 1 FIX + 1 DONE).
  - For divide-by-zero, done_out SHALL go high 1 cycle after the accepting edge.
REQ-025 DONE SHALL return to IDLE on the next edge unless a new start is accepted there.
REQ-026 stall_out SHALL equal busy_out & (I_MD_Start | I_MD_MfReq).
REQ-027 HI_out and LO_out SHALL change only on a FIX edge.
REQ-028 I_MD_Flush in CALC or FIX SHALL force IDLE on the next edge.
  - HI_out, LO_out and divZero_out SHALL be unchanged.
  - No done_out pulse SHALL be produced.
REQ-029 If I_MD_Flush and I_MD_Start are high together, the flush SHALL win and the start SHALL be dropped.
REQ-030 If flush and the FIX edge coincide, the flush SHALL win and HI_out/LO_out SHALL NOT be written.

Reset
REQ-031 RESET=0 SHALL immediately, without waiting for a clock edge, force:
  - state IDLE and counter 0;
  - HI_out=0 and LO_out=0;
  - busy_out=0, done_out=0, divZero_out=0 and stall_out=0.
REQ-032 An operation in progress when reset asserts SHALL be discarded.
  - After release the block SHALL accept a start on the first edge.

Verification
REQ-033 MULT, A=0xFFFFFFFE, B=0x00000003 -> at cycle 34: done_out pulses for 1 cycle, HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-034 MULTU, A=B=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001; busy_out is high for exactly 33 cycles.
REQ-035 DIV, A=0xFFFFFFF9, B=0x00000002 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 100/7 -> LO=14, HI=2.
REQ-036 DIVU with B=0 after HI=LO=0x12345678:
  - done_out pulses 1 cycle after the start;
  - divZero_out=1;
  - HI and LO remain 0x12345678.
REQ-037 Control during a busy MULT:
  - I_MD_MfReq=1 at cycle 5 -> stall_out=1 that cycle;
  - a start at cycle 6 is ignored;
  - I_MD_Flush at cycle 10 -> IDLE, no done_out pulse, HI/LO unchanged.
REQ-038 RESET low at cycle 20 of a DIV -> all outputs 0 with no clock edge needed; a new MULT after release completes correctly.

Source files
------------

// File: rtl/ex_muldiv_sequencer.sv
// Iterative 32-bit multiply/divide unit for the EX stage.
// Shift-add multiply and restoring divide, one bit per cycle, with
// sign correction applied once on the FIX edge.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | no operation; a start is accepted here
// CALC  | 32 iterations, one multiplier/quotient bit per cycle
// FIX   | sign correction, HI/LO written on the leaving edge
// DONE  | one-cycle completion pulse; a start is also accepted here
module ex_muldiv_sequencer (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        I_MD_Start,
    input  logic [1:0]  I_MD_Op,
    input  logic [31:0] I_MD_A,
    input  logic [31:0] I_MD_B,
    input  logic        I_MD_MfReq,
    input  logic        I_MD_Flush,
    output logic [31:0] HI_out,
    output logic [31:0] LO_out,
    output logic        busy_out,
    output logic        done_out,
    output logic        stall_out,
    output logic        divZero_out
);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t      state;
    logic [1:0]  op;
    logic        sign_a;
    logic        sign_b;
    logic [31:0] opa;
    logic [31:0] opb;
    logic [63:0] acc;
    logic [4:0]  cnt;

    // Op[1] selects divide, Op[0]=0 selects the signed variant.
    logic        in_div;
    logic        in_signed;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic        start_ok;

    logic        is_div;
    logic        is_signed;
    logic [32:0] mul_sum;
    logic [32:0] div_sh;
    logic [32:0] div_diff;
    logic        div_ge;
    logic [63:0] acc_step;
    logic [63:0] mul_res;
    logic [31:0] quot_res;
    logic [31:0] rem_res;

    // Operand conditioning and start acceptance.
    always_comb begin
        in_div    = I_MD_Op[1];
        in_signed = ~I_MD_Op[0];
        a_mag     = (in_signed && I_MD_A[31]) ? (32'd0 - I_MD_A) : I_MD_A;
        b_mag     = (in_signed && I_MD_B[31]) ? (32'd0 - I_MD_B) : I_MD_B;
        start_ok  = I_MD_Start && !I_MD_Flush && (state == IDLE || state == DONE);
    end

    // One iteration step and the final sign correction.
    // Multiply: acc = {partial product, remaining multiplier bits}.
    // Divide:   acc = {partial remainder, dividend bits / quotient bits}.
    always_comb begin
        is_div    = op[1];
        is_signed = ~op[0];
        mul_sum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opa} : 33'd0);
        div_sh    = acc[63:31];
        div_diff  = div_sh - {1'b0, opb};
        // Remainder stays below 2*divisor, so bit 32 is a clean borrow flag.
        div_ge    = ~div_diff[32];
        if (is_div)
            acc_step = {(div_ge ? div_diff[31:0] : div_sh[31:0]), acc[30:0], div_ge};
        else
            acc_step = {mul_sum, acc[31:1]};
        mul_res  = (is_signed && (sign_a ^ sign_b)) ? (64'd0 - acc) : acc;
        quot_res = (is_signed && (sign_a ^ sign_b)) ? (32'd0 - acc[31:0]) : acc[31:0];
        rem_res  = (is_signed && sign_a) ? (32'd0 - acc[63:32]) : acc[63:32];
    end

    // Sequencer FSM with registered busy/done and architectural HI/LO.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state       <= IDLE;
            op          <= 2'd0;
            sign_a      <= 1'b0;
            sign_b      <= 1'b0;
            opa         <= 32'd0;
            opb         <= 32'd0;
            acc         <= 64'd0;
            cnt         <= 5'd0;
            HI_out      <= 32'd0;
            LO_out      <= 32'd0;
            busy_out    <= 1'b0;
            done_out    <= 1'b0;
            divZero_out <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start_ok) begin
                        op          <= I_MD_Op;
                        sign_a      <= I_MD_A[31];
                        sign_b      <= I_MD_B[31];
                        opa         <= a_mag;
                        opb         <= b_mag;
                        acc         <= {32'd0, (in_div ? a_mag : b_mag)};
                        cnt         <= 5'd0;
                        if (in_div && (I_MD_B == 32'd0)) begin
                            state       <= DONE;
                            busy_out    <= 1'b0;
                            done_out    <= 1'b1;
                            divZero_out <= 1'b1;
                        end else begin
                            state       <= CALC;
                            busy_out    <= 1'b1;
                            done_out    <= 1'b0;
                            divZero_out <= 1'b0;
                        end
                    end else begin
                        state    <= IDLE;
                        busy_out <= 1'b0;
                        done_out <= 1'b0;
                    end
                end
                CALC: begin
                    if (I_MD_Flush) begin
                        state    <= IDLE;
                        busy_out <= 1'b0;
                    end else begin
                        acc <= acc_step;
                        cnt <= cnt + 5'd1;
                        if (cnt == 5'd31)
                            state <= FIX;
                    end
                end
                FIX: begin
                    busy_out <= 1'b0;
                    if (I_MD_Flush) begin
                        state <= IDLE;
                    end else begin
                        if (is_div) begin
                            HI_out <= rem_res;
                            LO_out <= quot_res;
                        end else begin
                            HI_out <= mul_res[63:32];
                            LO_out <= mul_res[31:0];
                        end
                        state    <= DONE;
                        done_out <= 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    busy_out <= 1'b0;
                    done_out <= 1'b0;
                end
            endcase
        end
    end

    // Hold the pipeline while busy if EX wants a new op or HI/LO.
    always_comb begin
        stall_out = busy_out & (I_MD_Start | I_MD_MfReq);
    end

endmodule
